// File: rtl/riscv_defines.sv
// riscv_defines: shared fetch-path FSM encoding and default prefetch buffer sizes
package riscv_defines;
  typedef enum logic [1:0] {IDLE, FETCH, BRANCH_WAIT} fetch_state_e;
  localparam int PREFETCH_DEPTH = 4;
  localparam int PREFETCH_MAX_OUTSTANDING = 2;
endpackage

// File: rtl/riscv_fetch_fifo.sv
// riscv_fetch_fifo: synchronous word FIFO; flush wins over push and pop
module riscv_fetch_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rd_ptr];
  // storage and pointers; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= wdata;
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/riscv_instr_prefetcher.sv
// riscv_instr_prefetcher: instruction fetch request/response buffer; PREFETCH_BYPASS_EN adds an empty-FIFO rvalid bypass
module riscv_instr_prefetcher import riscv_defines::*; #(
  parameter int DEPTH = PREFETCH_DEPTH,
  parameter int MAX_OUTSTANDING = PREFETCH_MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  input  logic        fetch_ready_i,
  input  logic        hold_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  fetch_state_e state, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d, target_q, target, head, data_sel;
  logic [OW-1:0] outstanding_q, discard_q, discard_d;
  logic [CW-1:0] count, count_eff;
  logic pend_q, to_target, accept, credit, drop, push, pop, empty, full;
  assign target = {branch_addr_i[31:2], 2'b00};
  assign to_target = branch_i & ~pend_q;
  assign count_eff = branch_i ? '0 : count;
  assign credit = (int'(count_eff) + int'(outstanding_q) < DEPTH) && (int'(outstanding_q) < MAX_OUTSTANDING);
  assign accept = instr_req_o & instr_gnt_i;
  assign drop = branch_i | (discard_q != '0);
  assign pop = fetch_valid_o & fetch_ready_i & ~hold_i & ~branch_i;
  assign busy_o = (outstanding_q != '0) || (state != IDLE);
`ifdef PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass = empty & instr_rvalid_i & ~drop;
  assign push = instr_rvalid_i & ~drop & ~full & ~(bypass & pop);
  assign fetch_valid_o = ~empty | bypass;
  assign data_sel = empty ? instr_rdata_i : head;
`else
  assign push = instr_rvalid_i & ~drop & ~full;
  assign fetch_valid_o = ~empty;
  assign data_sel = head;
`endif
  assign fetch_rdata_o = fetch_valid_o ? data_sel : '0;
  riscv_fetch_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk), .rst_n(rst_n), .flush(branch_i), .push(push), .pop(pop),
    .wdata(instr_rdata_i), .rdata(head), .count(count), .full(full), .empty(empty)
  );
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // next state: a branch against an ungranted request must wait for its grant
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = req_i ? FETCH : IDLE;
      FETCH: state_d = (branch_i && pend_q && !instr_gnt_i) ? BRANCH_WAIT : (!req_i && !(instr_req_o && !instr_gnt_i)) ? IDLE : FETCH;
      BRANCH_WAIT: state_d = instr_gnt_i ? FETCH : BRANCH_WAIT;
      default: state_d = IDLE;
    endcase
  end
  // bus outputs: a pending ungranted request is held at its address; otherwise a branch redirects at once
  always_comb begin
    instr_req_o = pend_q | (state == FETCH && req_i && credit);
    instr_addr_o = to_target ? target : fetch_addr_q;
  end
  // next fetch address and discard count; a request granted while waiting on a branch belongs to the old stream
  always_comb begin
    fetch_addr_d = to_target ? target + {29'd0, accept, 2'b00} : branch_i ? (accept ? target : fetch_addr_q) : (state == BRANCH_WAIT && accept) ? target_q : fetch_addr_q + {29'd0, accept, 2'b00};
    discard_d = branch_i ? outstanding_q - OW'(instr_rvalid_i) + OW'(accept & ~to_target) : discard_q - OW'(instr_rvalid_i & (discard_q != '0)) + OW'(accept & (state == BRANCH_WAIT));
  end
  // address, pending, outstanding and discard bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= '0;
      target_q <= '0;
      outstanding_q <= '0;
      discard_q <= '0;
      pend_q <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      target_q <= branch_i ? target : target_q;
      outstanding_q <= outstanding_q + OW'(accept) - OW'(instr_rvalid_i);
      discard_q <= discard_d;
      pend_q <= instr_req_o & ~instr_gnt_i;
    end
  end
endmodule
